// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_src_e;

   // FETCH must stay at zero: state_o reads as FETCH while reset forces it low
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
   } state_e;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_unit_alu_decoder.sv
// funct3/funct7 to ALU operation mapping shared by register and immediate ALU ops.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_imm,
   output alu_op_e    alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      unique case (funct3)
         3'b000:  alu_op = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional ILLEGAL_TRAP_EN adds a TRAP state and the illegal_instr output.
module multicycle_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 4,
   parameter int IMMSRC_W  = 3,
   parameter int STATE_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 zero,
   input  logic                 lt,
   input  logic                 ltu,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 RegWrite,
   output logic [1:0]           ALUsrcA,
   output logic [1:0]           ALUsrcB,
   output logic [ALUCTRL_W-1:0] ALUctrl,
   output logic [IMMSRC_W-1:0]  ImmSrc,
   output logic [1:0]           ResultSrc,
   output logic [STATE_W-1:0]   state_o
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                 illegal_instr
`endif
);

   state_e     state;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       unused_instr_bits;

   alu_op_e    dec_op;
   alu_op_e    alu_ctrl;
   imm_src_e   imm_src;
   logic [1:0] src_a, src_b, result_src;
   logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
   logic       take;
   logic       illegal;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign funct7b5          = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_imm   (state == EXECI),
      .alu_op   (dec_op)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         unique case (state)
            FETCH:  if (mem_ready) state <= DECODE;
            DECODE: begin
               unique case (opcode)
                  OP_LOAD, OP_STORE: state <= MEMADR;
                  OP_RTYPE:          state <= EXECR;
                  OP_ITYPE:          state <= EXECI;
                  OP_BRANCH:         state <= BRANCH;
                  OP_JAL:            state <= JAL;
`ifdef ILLEGAL_TRAP_EN
                  default:           state <= TRAP;
`else
                  default:           state <= FETCH;
`endif
               endcase
            end
            MEMADR: state <= opcode[5] ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state <= MEMWB;
            MEMWB:  state <= FETCH;
            MEMWR:  if (mem_ready) state <= FETCH;
            EXECR,
            EXECI:  state <= ALUWB;
            ALUWB:  state <= FETCH;
            BRANCH: state <= FETCH;
            JAL:    state <= ALUWB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:   state <= TRAP;
`endif
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      take = 1'b0;
      unique case (funct3)
         3'b000:  take = zero;
         3'b001:  take = !zero;
         3'b100:  take = lt;
         3'b101:  take = !lt;
         3'b110:  take = ltu;
         3'b111:  take = !ltu;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      src_a      = SRCA_PC;
      src_b      = SRCB_RS2;
      alu_ctrl   = ALU_ADD;
      imm_src    = IMM_I;
      result_src = RES_ALUOUT;
      illegal    = 1'b0;
      unique case (state)
         FETCH: begin
            mem_read = 1'b1;
            src_b    = SRCB_FOUR;
            pc_write = mem_ready;
            ir_write = mem_ready;
         end
         DECODE: begin
            src_a   = SRCA_OLDPC;
            src_b   = SRCB_IMM;
            imm_src = IMM_B;
         end
         MEMADR: begin
            src_a   = SRCA_RS1;
            src_b   = SRCB_IMM;
            imm_src = opcode[5] ? IMM_S : IMM_I;
         end
         MEMRD: begin
            mem_read = 1'b1;
            adr_src  = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            result_src = RES_MEM;
         end
         MEMWR: begin
            mem_write = 1'b1;
            adr_src   = 1'b1;
         end
         EXECR: begin
            src_a    = SRCA_RS1;
            alu_ctrl = dec_op;
         end
         EXECI: begin
            src_a    = SRCA_RS1;
            src_b    = SRCB_IMM;
            alu_ctrl = dec_op;
         end
         ALUWB: reg_write = 1'b1;
         BRANCH: begin
            src_a    = SRCA_RS1;
            alu_ctrl = ALU_SUB;
            pc_write = take;
         end
         JAL: begin
            src_a    = SRCA_OLDPC;
            src_b    = SRCB_FOUR;
            imm_src  = IMM_J;
            pc_write = 1'b1;
         end
         TRAP: illegal = 1'b1;
         default: ;
      endcase
      // reset overrides the state decode so an abandoned instruction never writes
      if (rst) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         adr_src    = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         src_a      = '0;
         src_b      = '0;
         alu_ctrl   = ALU_ADD;
         imm_src    = IMM_I;
         result_src = '0;
         illegal    = 1'b0;
      end
   end

   assign PCWrite   = pc_write;
   assign IRWrite   = ir_write;
   assign AdrSrc    = adr_src;
   assign MemRead   = mem_read;
   assign MemWrite  = mem_write;
   assign RegWrite  = reg_write;
   assign ALUsrcA   = src_a;
   assign ALUsrcB   = src_b;
   assign ALUctrl   = ALUCTRL_W'(alu_ctrl);
   assign ImmSrc    = IMMSRC_W'(imm_src);
   assign ResultSrc = result_src;
   assign state_o   = rst ? '0 : STATE_W'(state);
`ifdef ILLEGAL_TRAP_EN
   assign illegal_instr = illegal;
`else
   logic unused_illegal;
   assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit (honours ILLEGAL_TRAP_EN when defined).
module tb_multicycle_ctrl_unit;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, zero, lt, ltu, mem_ready;
   logic [31:0] instr;
   logic        PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
   logic [1:0]  ALUsrcA, ALUsrcB, ResultSrc;
   logic [3:0]  ALUctrl;
   logic [2:0]  ImmSrc;
   logic [3:0]  state_o;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal_instr;
`endif

   int checks = 0;
   int errors = 0;

   multicycle_ctrl_unit #(.ALUCTRL_W(4), .IMMSRC_W(3), .STATE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .zero      (zero),
      .lt        (lt),
      .ltu       (ltu),
      .mem_ready (mem_ready),
      .PCWrite   (PCWrite),
      .IRWrite   (IRWrite),
      .AdrSrc    (AdrSrc),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .RegWrite  (RegWrite),
      .ALUsrcA   (ALUsrcA),
      .ALUsrcB   (ALUsrcB),
      .ALUctrl   (ALUctrl),
      .ImmSrc    (ImmSrc),
      .ResultSrc (ResultSrc),
      .state_o   (state_o)
`ifdef ILLEGAL_TRAP_EN
      ,
      .illegal_instr (illegal_instr)
`endif
   );

   always #5 clk = ~clk;

   typedef enum {C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_ILL} cls_e;

   // per-instruction observation / expectation record
   typedef struct {
      int         regw, memw, memr, pcw, irw, adr, fetchc;
      logic [3:0] alu1, alu2;
      logic [1:0] srca1, srcb1, srca2, srcb2, rsrc;
      logic [2:0] imm1, imm2;
      logic [3:0] state_end;
   } rec_t;

   function automatic cls_e classify(input logic [31:0] in);
      case (in[6:0])
         7'b0000011: return C_LOAD;
         7'b0100011: return C_STORE;
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         default:    return C_ILL;
      endcase
   endfunction

   function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b5, input logic isr);
      case (f3)
         3'd0: return (isr && b5) ? ALU_SUB : ALU_ADD;
         3'd1: return ALU_SLL;
         3'd2: return ALU_SLT;
         3'd3: return ALU_SLTU;
         3'd4: return ALU_XOR;
         3'd5: return b5 ? ALU_SRA : ALU_SRL;
         3'd6: return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic int ref_take(input logic [2:0] f3, input logic z, l, lu);
      case (f3)
         3'd0: return int'(z);
         3'd1: return int'(!z);
         3'd4: return int'(l);
         3'd5: return int'(!l);
         3'd6: return int'(lu);
         3'd7: return int'(!lu);
         default: return 0;
      endcase
   endfunction

   function automatic int ref_cycles(input cls_e c, input int f, m);
      case (c)
         C_LOAD:  return f + 5 + m;
         C_STORE: return f + 4 + m;
         C_BR:    return f + 3;
         C_ILL:   return f + 2;
         default: return f + 4;
      endcase
   endfunction

   function automatic rec_t model(input logic [31:0] in, input int f, m, input logic z, l, lu);
      rec_t e;
      cls_e c = classify(in);
      e = '{default: 0};
      e.irw = 1; e.fetchc = f + 1; e.memr = f + 1; e.pcw = 1;
      e.alu1 = ALU_ADD; e.srca1 = 2'b01; e.srcb1 = 2'b01; e.imm1 = IMM_B;
      e.state_end = FETCH;
      case (c)
         C_LOAD:  begin e.memr += m + 1; e.adr = m + 1; e.regw = 1; e.rsrc = 2'b01;
                        e.alu2 = ALU_ADD; e.srca2 = 2'b10; e.srcb2 = 2'b01; e.imm2 = IMM_I; end
         C_STORE: begin e.memw = m + 1; e.adr = m + 1;
                        e.alu2 = ALU_ADD; e.srca2 = 2'b10; e.srcb2 = 2'b01; e.imm2 = IMM_S; end
         C_R:     begin e.regw = 1; e.alu2 = ref_alu(in[14:12], in[30], 1'b1);
                        e.srca2 = 2'b10; e.srcb2 = 2'b00; end
         C_I:     begin e.regw = 1; e.alu2 = ref_alu(in[14:12], in[30], 1'b0);
                        e.srca2 = 2'b10; e.srcb2 = 2'b01; e.imm2 = IMM_I; end
         C_BR:    begin e.pcw += ref_take(in[14:12], z, l, lu);
                        e.alu2 = ALU_SUB; e.srca2 = 2'b10; e.srcb2 = 2'b00; end
         C_JAL:   begin e.pcw += 1; e.regw = 1; e.rsrc = 2'b00;
                        e.alu2 = ALU_ADD; e.srca2 = 2'b01; e.srcb2 = 2'b10; e.imm2 = IMM_J; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one instruction for ncyc cycles with f fetch stalls and m memory stalls.
   task automatic run_instr(input logic [31:0] in, input int f, m, input logic z, l, lu,
                            input int ncyc, output rec_t o);
      cls_e c = classify(in);
      bit memc = (c == C_LOAD) || (c == C_STORE);
      o = '{default: 0};
      instr = in; zero = z; lt = l; ltu = lu;
      for (int cy = 0; cy < ncyc; cy++) begin
         int p = cy - f;
         if (cy < f)                          mem_ready = 1'b0;
         else if (cy == f)                    mem_ready = 1'b1;
         else if (memc && p >= 3 && p < 3+m) mem_ready = 1'b0;
         else if (memc && p == 3+m)          mem_ready = 1'b1;
         else                                 mem_ready = 1'($urandom_range(1));
         @(negedge clk);
         o.regw += int'(RegWrite); o.memw += int'(MemWrite); o.memr += int'(MemRead);
         o.pcw  += int'(PCWrite);  o.irw  += int'(IRWrite);  o.adr  += int'(AdrSrc);
         o.fetchc += int'(state_o == FETCH);
         if (p == 1) begin o.alu1 = ALUctrl; o.srca1 = ALUsrcA; o.srcb1 = ALUsrcB; o.imm1 = ImmSrc; end
         if (p == 2) begin o.alu2 = ALUctrl; o.srca2 = ALUsrcA; o.srcb2 = ALUsrcB; o.imm2 = ImmSrc; end
         if (RegWrite === 1'b1) o.rsrc = ResultSrc;
         tick();
      end
      o.state_end = state_o;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; instr = 32'h002081B3; zero = 0; lt = 0; ltu = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b0) begin
            errors++; $display("FAIL reset_enables: got %b expected 00000",
                               {PCWrite, IRWrite, MemRead, MemWrite, RegWrite});
         end
         checks++;
         if (state_o !== 4'(FETCH)) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, FETCH);
         end
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
         errors++; $display("FAIL reset_first_fetch: got IRWrite=%b PCWrite=%b expected 1 1", IRWrite, PCWrite);
      end
      tick();
      repeat (3) tick();
      checks++;
      if (state_o !== 4'(FETCH)) begin
         errors++; $display("FAIL reset_then_add_end: got %0d expected %0d", state_o, FETCH);
      end
   endtask

   task automatic test_alu_r();
      rec_t o;
      run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 4, o);
      checks++;
      if (o.regw !== 1) begin errors++; $display("FAIL add_regwrite: got %0d expected 1", o.regw); end
      checks++;
      if ({o.alu2, o.srca2, o.srcb2} !== {4'(ALU_ADD), 2'b10, 2'b00}) begin
         errors++; $display("FAIL add_exec: got %h expected %h", {o.alu2, o.srca2, o.srcb2}, {4'(ALU_ADD), 2'b10, 2'b00});
      end
      checks++;
      if (o.state_end !== 4'(FETCH) || o.fetchc !== 1) begin
         errors++; $display("FAIL add_length: got state=%0d fetch_cycles=%0d expected %0d 1", o.state_end, o.fetchc, FETCH);
      end
   endtask

   task automatic test_load_stall();
      rec_t o;
      run_instr(32'h00402283, 0, 3, 1'b0, 1'b0, 1'b0, 8, o);
      checks++;
      if (o.adr !== 4 || o.memr !== 5) begin
         errors++; $display("FAIL lw_memrd_hold: got adr=%0d memread=%0d expected 4 5", o.adr, o.memr);
      end
      checks++;
      if (o.regw !== 1 || o.rsrc !== 2'b01) begin
         errors++; $display("FAIL lw_writeback: got regw=%0d rsrc=%b expected 1 01", o.regw, o.rsrc);
      end
      checks++;
      if (o.imm2 !== 3'(IMM_I) || o.state_end !== 4'(FETCH)) begin
         errors++; $display("FAIL lw_memadr: got imm=%0d state=%0d expected %0d %0d", o.imm2, o.state_end, IMM_I, FETCH);
      end
   endtask

   task automatic test_store();
      rec_t o;
      run_instr(32'h00502423, 0, 0, 1'b0, 1'b0, 1'b0, 4, o);
      checks++;
      if (o.memw !== 1 || o.regw !== 0) begin
         errors++; $display("FAIL sw_single: got memw=%0d regw=%0d expected 1 0", o.memw, o.regw);
      end
      checks++;
      if (o.imm2 !== 3'(IMM_S) || o.state_end !== 4'(FETCH)) begin
         errors++; $display("FAIL sw_memadr: got imm=%0d state=%0d expected %0d %0d", o.imm2, o.state_end, IMM_S, FETCH);
      end
      run_instr(32'h00502423, 1, 2, 1'b0, 1'b0, 1'b0, 7, o);
      checks++;
      if (o.memw !== 3 || o.state_end !== 4'(FETCH)) begin
         errors++; $display("FAIL sw_stall: got memw=%0d state=%0d expected 3 %0d", o.memw, o.state_end, FETCH);
      end
   endtask

   task automatic test_branch();
      rec_t o;
      run_instr(32'h00000463, 0, 0, 1'b1, 1'b0, 1'b0, 3, o);
      checks++;
      if (o.pcw !== 2) begin errors++; $display("FAIL beq_taken: got pcw=%0d expected 2", o.pcw); end
      run_instr(32'h00000463, 0, 0, 1'b0, 1'b0, 1'b0, 3, o);
      checks++;
      if (o.pcw !== 1) begin errors++; $display("FAIL beq_not_taken: got pcw=%0d expected 1", o.pcw); end
      run_instr(32'h00001463, 0, 0, 1'b0, 1'b0, 1'b0, 3, o);
      checks++;
      if (o.pcw !== 2 || o.alu2 !== 4'(ALU_SUB)) begin
         errors++; $display("FAIL bne_taken: got pcw=%0d alu=%0d expected 2 %0d", o.pcw, o.alu2, ALU_SUB);
      end
   endtask

   task automatic test_reset_mid();
      instr = 32'h00502423; zero = 0; lt = 0; ltu = 0;
      mem_ready = 1'b1; tick(); tick(); tick();
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (MemWrite !== 1'b1) begin errors++; $display("FAIL mid_sw_memwrite: got %b expected 1", MemWrite); end
      tick();
      rst = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
         errors++; $display("FAIL mid_sw_abort: got MemWrite=%b RegWrite=%b expected 0 0", MemWrite, RegWrite);
      end
      tick(); rst = 1'b0;
      checks++;
      if (state_o !== 4'(FETCH)) begin errors++; $display("FAIL mid_sw_state: got %0d expected %0d", state_o, FETCH); end
      instr = 32'h00402283;
      repeat (4) tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (RegWrite !== 1'b0) begin errors++; $display("FAIL mid_lw_abort: got RegWrite=%b expected 0", RegWrite); end
      tick(); rst = 1'b0;
      checks++;
      if (state_o !== 4'(FETCH)) begin errors++; $display("FAIL mid_lw_state: got %0d expected %0d", state_o, FETCH); end
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
      instr = 32'hFFFFFFFF; mem_ready = 1'b1;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'($urandom_range(1));
         @(negedge clk);
         checks++;
         if (illegal_instr !== 1'b1 || {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0) begin
            errors++; $display("FAIL trap_hold: got illegal=%b enables=%b expected 1 0000",
                               illegal_instr, {PCWrite, IRWrite, MemWrite, RegWrite});
         end
         tick();
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (illegal_instr !== 1'b0) begin errors++; $display("FAIL trap_reset: got %b expected 0", illegal_instr); end
      tick(); rst = 1'b0;
      checks++;
      if (state_o !== 4'(FETCH)) begin errors++; $display("FAIL trap_exit: got %0d expected %0d", state_o, FETCH); end
`else
      rec_t o;
      run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1'b0, 2, o);
      checks++;
      if (o.regw !== 0 || o.memw !== 0 || o.pcw !== 1) begin
         errors++; $display("FAIL illegal_nop: got regw=%0d memw=%0d pcw=%0d expected 0 0 1", o.regw, o.memw, o.pcw);
      end
      checks++;
      if (o.state_end !== 4'(FETCH)) begin errors++; $display("FAIL illegal_return: got %0d expected %0d", o.state_end, FETCH); end
`endif
   endtask

   task automatic test_random();
      logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
      for (int n = 0; n < 150; n++) begin
         rec_t o, e;
         logic [31:0] in = $urandom;
         int f = $urandom_range(2);
         int m = $urandom_range(2);
         logic z = 1'($urandom_range(1)), l = 1'($urandom_range(1)), lu = 1'($urandom_range(1));
         int sel;
         cls_e c;
`ifdef ILLEGAL_TRAP_EN
         sel = $urandom_range(5);
`else
         sel = $urandom_range(6);
`endif
         if (sel < 6) in[6:0] = ops[sel];
         else while (classify(in) != C_ILL) in[6:0] = 7'($urandom);
         c = classify(in);
         e = model(in, f, m, z, l, lu);
         run_instr(in, f, m, z, l, lu, ref_cycles(c, f, m), o);
         checks++;
         if ({o.regw, o.memw, o.memr, o.pcw, o.irw, o.adr, o.fetchc} !== {e.regw, e.memw, e.memr, e.pcw, e.irw, e.adr, e.fetchc}) begin
            errors++; $display("FAIL rnd_counts %h: got rw=%0d mw=%0d mr=%0d pc=%0d ir=%0d adr=%0d fc=%0d expected %0d %0d %0d %0d %0d %0d %0d",
               in, o.regw, o.memw, o.memr, o.pcw, o.irw, o.adr, o.fetchc, e.regw, e.memw, e.memr, e.pcw, e.irw, e.adr, e.fetchc);
         end
         checks++;
         if ({o.alu1, o.srca1, o.srcb1, o.imm1} !== {e.alu1, e.srca1, e.srcb1, e.imm1}) begin
            errors++; $display("FAIL rnd_decode %h: got %h expected %h", in, {o.alu1, o.srca1, o.srcb1, o.imm1}, {e.alu1, e.srca1, e.srcb1, e.imm1});
         end
         checks++;
         if ({o.alu2, o.srca2, o.srcb2} !== {e.alu2, e.srca2, e.srcb2}) begin
            errors++; $display("FAIL rnd_exec %h: got %h expected %h", in, {o.alu2, o.srca2, o.srcb2}, {e.alu2, e.srca2, e.srcb2});
         end
         if (c inside {C_LOAD, C_STORE, C_I, C_JAL}) begin
            checks++;
            if (o.imm2 !== e.imm2) begin errors++; $display("FAIL rnd_imm %h: got %0d expected %0d", in, o.imm2, e.imm2); end
         end
         if (e.regw == 1) begin
            checks++;
            if (o.rsrc !== e.rsrc) begin errors++; $display("FAIL rnd_resultsrc %h: got %b expected %b", in, o.rsrc, e.rsrc); end
         end
         checks++;
         if (o.state_end !== e.state_end) begin
            errors++; $display("FAIL rnd_end_state %h: got %0d expected %0d", in, o.state_end, e.state_end);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_r();
      test_load_stall();
      test_store();
      test_branch();
      test_reset_mid();
      test_illegal();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
